// File: rtl/led_arbiter.sv
// Three-requester LED bank arbiter: round-robin grant, non-preemptive hold of
// HOLD_CYCLES clocks, and back-to-back re-arbitration when the hold expires.
module led_arbiter #(
    parameter int WIDTH       = 6,
    parameter int HOLD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] led,
    output logic [2:0]       grant,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [1:0]       last_q;
    logic [2:0]       grant_q;
    logic [WIDTH-1:0] led_q;
    logic             busy_q;

    logic [1:0]       c0, c1, c2;
    logic [1:0]       win_idx;
    logic             win_vld;
    logic [2:0]       grant_d;
    logic [WIDTH-1:0] led_d;

    function automatic logic [1:0] next_idx(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search starts just after the last owner, so the owner itself is checked last.
    always_comb begin
        c0      = next_idx(last_q);
        c1      = next_idx(c0);
        c2      = next_idx(c1);
        win_idx = c0;
        win_vld = 1'b1;
        if (req[c0]) begin
            win_idx = c0;
        end else if (req[c1]) begin
            win_idx = c1;
        end else if (req[c2]) begin
            win_idx = c2;
        end else begin
            win_vld = 1'b0;
        end
        grant_d = 3'b001 << win_idx;
        case (win_idx)
            2'd0:    led_d = data0;
            2'd1:    led_d = data1;
            default: led_d = data2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            last_q  <= 2'd2;
            grant_q <= 3'b000;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LOAD;
                        last_q  <= win_idx;
                        grant_q <= grant_d;
                        led_q   <= led_d;
                        busy_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (win_vld) begin
                        cnt_q   <= HOLD_LOAD;
                        last_q  <= win_idx;
                        grant_q <= grant_d;
                        led_q   <= led_d;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= 3'b000;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign led   = led_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter: a HOLD_CYCLES=8 instance driven from a vector
// table plus hand-written sequences, and a HOLD_CYCLES=1 instance for rotation.
module tb_led_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req_a = 3'b000;
    logic [2:0] req_b = 3'b000;
    logic [5:0] data0 = 6'h01;
    logic [5:0] data1 = 6'h02;
    logic [5:0] data2 = 6'h04;
    logic [5:0] led_a, led_b;
    logic [2:0] grant_a, grant_b;
    logic       busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] r;
        logic [5:0] d0, d1, d2;
        logic [2:0] eg;
        logic [5:0] el;
        logic       eb;
    } vec_t;

    vec_t tbl[$];

    led_arbiter #(.WIDTH(6), .HOLD_CYCLES(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .data0(data0), .data1(data1), .data2(data2),
        .led(led_a), .grant(grant_a), .busy(busy_a)
    );

    led_arbiter #(.WIDTH(6), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .data0(data0), .data1(data1), .data2(data2),
        .led(led_b), .grant(grant_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] r, input logic [5:0] d0, input logic [5:0] d1,
                       input logic [5:0] d2, input logic [2:0] eg, input logic [5:0] el,
                       input logic eb, input int n);
        vec_t v;
        v.r = r; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.eg = eg; v.el = el; v.eb = eb;
        repeat (n) tbl.push_back(v);
    endtask

    // Structural invariants on both instances every cycle.
    always @(negedge clk) begin
        check("onehot_a", 0, {31'd0, $onehot0(grant_a)}, 32'd1);
        check("busy_or_a", 0, {31'd0, busy_a}, {31'd0, |grant_a});
        check("onehot_b", 0, {31'd0, $onehot0(grant_b)}, 32'd1);
        check("busy_or_b", 0, {31'd0, busy_b}, {31'd0, |grant_b});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full rotation with all three requesting, then owner 0 finishes alone.
        add(3'b111, 6'h01, 6'h02, 6'h04, 3'b001, 6'h01, 1'b1, 8);
        add(3'b111, 6'h01, 6'h02, 6'h04, 3'b010, 6'h02, 1'b1, 8);
        add(3'b111, 6'h01, 6'h02, 6'h04, 3'b100, 6'h04, 1'b1, 8);
        add(3'b111, 6'h01, 6'h02, 6'h04, 3'b001, 6'h01, 1'b1, 2);
        add(3'b000, 6'h01, 6'h02, 6'h04, 3'b001, 6'h01, 1'b1, 6);
        add(3'b000, 6'h01, 6'h02, 6'h04, 3'b000, 6'h01, 1'b0, 1);
        // Single-cycle request from requester 1.
        add(3'b010, 6'h01, 6'h02, 6'h04, 3'b010, 6'h02, 1'b1, 1);
        add(3'b000, 6'h01, 6'h02, 6'h04, 3'b010, 6'h02, 1'b1, 7);
        add(3'b000, 6'h01, 6'h02, 6'h04, 3'b000, 6'h02, 1'b0, 2);
        add(3'b000, 6'h3F, 6'h02, 6'h04, 3'b000, 6'h02, 1'b0, 1);
        // Owner 0: data and req change mid-hold.
        add(3'b001, 6'h01, 6'h02, 6'h04, 3'b001, 6'h01, 1'b1, 2);
        add(3'b000, 6'h3F, 6'h02, 6'h04, 3'b001, 6'h01, 1'b1, 6);
        add(3'b000, 6'h3F, 6'h02, 6'h04, 3'b000, 6'h01, 1'b0, 1);
        // last=0, req 101 skips 1 and picks 2; then 0 twice as sole requester.
        add(3'b101, 6'h3F, 6'h02, 6'h04, 3'b100, 6'h04, 1'b1, 1);
        add(3'b101, 6'h3F, 6'h02, 6'h15, 3'b100, 6'h04, 1'b1, 7);
        add(3'b001, 6'h01, 6'h02, 6'h15, 3'b001, 6'h01, 1'b1, 1);
        add(3'b001, 6'h2A, 6'h02, 6'h15, 3'b001, 6'h01, 1'b1, 7);
        add(3'b001, 6'h2A, 6'h02, 6'h15, 3'b001, 6'h2A, 1'b1, 1);
        add(3'b000, 6'h2A, 6'h02, 6'h15, 3'b001, 6'h2A, 1'b1, 7);
        add(3'b000, 6'h2A, 6'h02, 6'h15, 3'b000, 6'h2A, 1'b0, 1);

        #1 rst_n = 1'b0;
        #1;
        check("rst_grant", 0, {29'd0, grant_a}, 32'd0);
        check("rst_busy", 0, {31'd0, busy_a}, 32'd0);
        check("rst_led", 0, {26'd0, led_a}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            req_a = tbl[i].r;
            data0 = tbl[i].d0;
            data1 = tbl[i].d1;
            data2 = tbl[i].d2;
            @(posedge clk);
            #1;
            check("tbl_grant", i, {29'd0, grant_a}, {29'd0, tbl[i].eg});
            check("tbl_led", i, {26'd0, led_a}, {26'd0, tbl[i].el});
            check("tbl_busy", i, {31'd0, busy_a}, {31'd0, tbl[i].eb});
        end

        // Reset in the 4th hold cycle of owner 1 aborts the grant at once.
        data0 = 6'h01; data1 = 6'h02; data2 = 6'h04;
        req_a = 3'b010;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            req_a = 3'b000;
            check("mid_grant", k, {29'd0, grant_a}, 32'b010);
            check("mid_led", k, {26'd0, led_a}, 32'h02);
        end
        rst_n = 1'b0;
        #2;
        check("async_grant", 0, {29'd0, grant_a}, 32'd0);
        check("async_busy", 0, {31'd0, busy_a}, 32'd0);
        check("async_led", 0, {26'd0, led_a}, 32'd0);
        #1 rst_n = 1'b1;
        req_a = 3'b111;
        @(posedge clk);
        #1;
        req_a = 3'b000;
        check("post_rst_grant", 0, {29'd0, grant_a}, 32'b001);
        check("post_rst_led", 0, {26'd0, led_a}, 32'h01);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_hold", k, {29'd0, grant_a}, 32'b001);
        end
        @(posedge clk);
        #1;
        check("post_rst_idle", 0, {31'd0, busy_a}, 32'd0);

        // HOLD_CYCLES=1 instance: 101 alternates 0 and 2 every cycle.
        req_b = 3'b101;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("rot_grant", k, {29'd0, grant_b}, (k % 2 == 0) ? 32'b001 : 32'b100);
            check("rot_led", k, {26'd0, led_b}, (k % 2 == 0) ? 32'h01 : 32'h04);
        end
        req_b = 3'b000;
        @(posedge clk);
        #1;
        check("rot_idle_grant", 0, {29'd0, grant_b}, 32'd0);
        check("rot_idle_busy", 0, {31'd0, busy_b}, 32'd0);
        check("rot_idle_led", 0, {26'd0, led_b}, 32'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter: WIDTH, 6, width of the LED bank and of each requester data word.
REQ-002 Parameter: HOLD_CYCLES, 8, clock cycles a granted requester owns the LED bank (legal range 1..255).
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  3  per-requester request, bit i = requester i.
REQ-006 Port: data0  input  WIDTH  requester 0 display word.
REQ-007 Port: data1  input  WIDTH  requester 1 display word.
REQ-008 Port: data2  input  WIDTH  requester 2 display word.
REQ-009 Port: led  output  WIDTH  registered LED bank drive.
REQ-010 Port: grant  output  3  registered one-hot grant, all-zero when no owner.
REQ-011 Port: busy  output  1  registered, high while any grant is asserted.

Function
REQ-012 FSM has exactly two states, IDLE and HOLD.
REQ-013 IDLE, req == 0: remain IDLE; grant = 0, busy = 0, led unchanged.
REQ-014 IDLE, req != 0 at edge N: select winner by round-robin; from edge N, grant = one-hot winner, busy = 1, led = winner's data word sampled at edge N; enter HOLD.
REQ-015 Round-robin: priority order starts at the requester after the last granted (last_ptr + 1 mod 3) and wraps; only set req bits are eligible.
REQ-016 last_ptr updates to the winner on every grant.
REQ-017 Hold counter loads HOLD_CYCLES-1 on grant, decrements once per cycle in HOLD; grant stays asserted for exactly HOLD_CYCLES cycles.
REQ-018 led is latched once at grant; data-word changes during HOLD do not affect led.
REQ-019 Non-preemptive: deasserting the owner's req, or asserting other reqs, during HOLD does not change grant, led or counter.
REQ-020 At the edge where the counter is 0: if req != 0, re-arbitrate in the same edge (back-to-back, no idle cycle), applying REQ-014/015 with the updated last_ptr; the current owner is eligible again only if no other req is set.
REQ-021 At the edge where the counter is 0 and req == 0: enter IDLE; grant = 0, busy = 0, led holds the last displayed word.
REQ-022 HOLD_CYCLES = 1: every grant lasts one cycle; continuous requests rotate every cycle.
REQ-023 grant is never multi-hot; busy == |grant at all times.

Reset
REQ-024 rst_n low asynchronously forces: state = IDLE, grant = 0, busy = 0, led = 0, counter = 0, last_ptr = 2 (requester 0 has first priority).
REQ-025 Reset asserted mid-HOLD aborts the grant immediately, with no completion of the remaining hold cycles.
REQ-026 First arbitration occurs at the first rising edge after rst_n deasserts with req != 0.

Verification
REQ-027 Reset release, req = 3'b111, data0 = 6'h01, data1 = 6'h02, data2 = 6'h04, HOLD_CYCLES = 8 -> grant 001/led 01 for 8 cycles, then 010/02 for 8, then 100/04 for 8, then 001 again, no gaps.
REQ-028 req = 3'b010 for a single cycle from IDLE -> grant = 010 for exactly 8 cycles, then IDLE with led = 6'h02 retained and busy = 0.
REQ-029 Owner 0 is granted; data0 changes to 6'h3F and req[0] drops on the 3rd hold cycle -> led stays 6'h01 and grant = 001 for the full 8 cycles.
REQ-030 Owner 1 is granted; rst_n is pulsed low on the 4th hold cycle -> grant, busy and led read 0 before the next clock edge; after release with req = 3'b111, requester 0 is granted first.
REQ-031 HOLD_CYCLES = 1, req = 3'b101 held -> grant alternates 001, 100, 001, ... every cycle and 010 is never asserted.
REQ-032 Across all scenarios, the assertions one-hot(grant) or grant == 0, and busy == |grant, hold on every cycle.
